gpr_bank: RTL and testbench
===========================

# gpr_bank

Parametrised general-purpose register bank: successor to the two-read/one-write GPR. Adds configurable width, depth and read-port count, a second write port, a per-register busy scoreboard for the pipeline's hazard unit, and a sequential clear engine. Because of the clear engine the storage needs no per-entry reset and can map to RAM. Sits between the decode stage (reads, issue) and the writeback/load stages (writes).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1, entry 0 always reads 0, ignores writes and never becomes busy
- clk  in  1  clock
- reset  in  1  reset; one clock; reset is synchronous and active-high
- Clear  in  1  pulse in IDLE starts a clear sequence
- Ready  out  1  high when the bank is in IDLE (not clearing)
- RdAddr  in  NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
- RdData  out  NUM_RD*DATA_W  read data, combinational
- RdBusy  out  NUM_RD  busy bit of each read address, combinational
- WE0_  in  1  write port 0 enable, active-low (writeback, priority port)
- WrAddr0  in  ADDR_W  port 0 address
- WrData0  in  DATA_W  port 0 data
- WE1_, WrAddr1, WrData1  in  1/ADDR_W/DATA_W  write port 1 (load return), same meaning
- Issue  in  1  marks IssueAddr as having a pending producer
- IssueAddr  in  ADDR_W  destination register being issued

## Operation
- FSM states: CLEAR, IDLE.
- reset, or Clear in IDLE, enters CLEAR with counter = 0.
- CLEAR: each cycle writes 0 to entry[counter] and clears busy[counter], then increments the counter. The cycle with counter = DEPTH-1 moves the FSM to IDLE.
- Clear asserted during CLEAR restarts the counter at 0.
- During CLEAR: WE0_, WE1_ and Issue are ignored; RdData = 0; RdBusy = 0.
- IDLE, writes: an enabled port writes its data at the clock edge. Both ports to the same address: port 0 data wins. With ZERO_REG = 1, writes to address 0 are dropped.
- Scoreboard: Issue sets busy[IssueAddr]; any enabled write clears busy[WrAddr]. Set and clear on the same address in the same cycle: set wins (new producer). With ZERO_REG = 1, Issue to address 0 is ignored.
- Reads: RdData[k] = entry[RdAddr[k]], subject to the bypass (see Configuration). With ZERO_REG = 1, address 0 reads 0.
- RdBusy[k] = busy[RdAddr[k]] as registered; a same-cycle write does not clear it combinationally.

## Timing
- Reset values: Ready = 0, RdBusy = 0, RdData = 0, FSM = CLEAR, counter = 0.
- Ready rises exactly DEPTH cycles after the first clock edge with reset low (32 cycles at ADDR_W = 5).
- Write latency: data is visible to non-bypassed reads in the cycle after the edge.
- Issue latency: busy is visible on RdBusy in the cycle after Issue.
- Reset asserted mid-CLEAR or in IDLE: takes effect at the next edge, restarts CLEAR at 0 and drops Ready.

## Configuration
- GPR_BYPASS_EN defined: a read address matching an enabled write in IDLE returns the write data in the same cycle. Port 0 data wins over port 1; address 0 with ZERO_REG still returns 0.
- GPR_BYPASS_EN undefined: reads always return stored contents; written data appears the next cycle. This removes the write-to-read combinational path.

## Structure
- Shared package (cpu include): clear-FSM state encoding (GPR_ST_CLEAR, GPR_ST_IDLE), the ENABLE_/DISABLE_ active-low constants, and default width/address constants.
- One natural sub-module, gpr_scoreboard: the busy vector, set/clear priority and per-port busy lookup.
- Storage and clear FSM stay in gpr_bank.

## Test plan
- Release reset, poll Ready -> Ready = 0 for 32 cycles, then 1; every read returns 0 and RdBusy = 0.
- Write 0xDEADBEEF to r5 via port 0, read r5 next cycle -> 0xDEADBEEF. With GPR_BYPASS_EN, the same-cycle read also returns 0xDEADBEEF; without it, the same-cycle read returns 0.
- Both ports write r7 (port 0: 0x11, port 1: 0x22) -> r7 = 0x11. Write 0x55 to r0 -> r0 still reads 0.
- Issue r9 -> RdBusy = 1 next cycle. Port 1 write to r9 -> busy clears next cycle. Issue r9 and write r9 in the same cycle -> busy stays 1.
- Write r3 = 0x1234, pulse Clear -> Ready = 0 for 32 cycles; writes and Issue in that window are ignored; afterwards r3 reads 0.
- Pulse Clear again at clear cycle 10 -> Ready returns 32 cycles after the second pulse. Reset at cycle 20 of a clear -> same restart.

Source files
------------

// File: rtl/gpr_bank_pkg.sv
// Shared definitions for the general-purpose register bank: clear-engine
// state encoding, active-low enable constants and default geometry.
package gpr_bank_pkg;

  typedef enum logic {
    GPR_ST_CLEAR = 1'b0,
    GPR_ST_IDLE  = 1'b1
  } gpr_state_e;

  // Write enables on the bank are active-low.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int GPR_DATA_W = 32;
  localparam int GPR_ADDR_W = 5;

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register busy scoreboard for the hazard unit. A register becomes busy
// when a producer is issued to it and idle again when any write lands on it.
// A same-cycle issue and write to one register leaves it busy (new producer).
module gpr_scoreboard
  import gpr_bank_pkg::*;
#(
  parameter int ADDR_W   = GPR_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     wclr0_en,
  input  logic [ADDR_W-1:0]        wclr0_addr,
  input  logic                     wclr1_en,
  input  logic [ADDR_W-1:0]        wclr1_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Next busy vector: clears first, then a new issue overrides them.
  always_comb begin
    busy_d = busy_q;
    if (clr_en)   busy_d[clr_addr]   = 1'b0;
    if (wclr0_en) busy_d[wclr0_addr] = 1'b0;
    if (wclr1_en) busy_d[wclr1_addr] = 1'b0;
    if (set_en)   busy_d[set_addr]   = 1'b1;
    if (ZERO_REG) busy_d[0]          = 1'b0;
  end

  // Busy state register.
  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // Registered busy lookup for every read port (no same-cycle write effect).
  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_busy[k] = busy_q[rd_addr[k*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/gpr_bank.sv
// Parametrised GPR bank with NUM_RD combinational read ports, two write ports
// (port 0 has priority), a busy scoreboard and a sequential clear engine that
// zeroes one entry per cycle so the storage itself carries no reset.
// Optional feature: define GPR_BYPASS_EN to forward same-cycle write data to
// matching read ports; left undefined, reads see stored contents only.
module gpr_bank
  import gpr_bank_pkg::*;
#(
  parameter int DATA_W   = GPR_DATA_W,
  parameter int ADDR_W   = GPR_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Clear,
  output logic                     Ready,
  input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
  output logic [NUM_RD*DATA_W-1:0] RdData,
  output logic [NUM_RD-1:0]        RdBusy,
  input  logic                     WE0_,
  input  logic [ADDR_W-1:0]        WrAddr0,
  input  logic [DATA_W-1:0]        WrData0,
  input  logic                     WE1_,
  input  logic [ADDR_W-1:0]        WrAddr1,
  input  logic [DATA_W-1:0]        WrData1,
  input  logic                     Issue,
  input  logic [ADDR_W-1:0]        IssueAddr
);

  localparam int DEPTH = 1 << ADDR_W;

  gpr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              idle;
  logic              clearing;
  logic              wr0_en, wr1_en, iss_en;
  logic [NUM_RD-1:0] sb_busy;
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rd;

  assign idle     = (state_q == GPR_ST_IDLE);
  assign clearing = (state_q == GPR_ST_CLEAR);
  assign Ready    = ready_q;

  // Qualified write/issue strobes: only live in IDLE, address 0 is inert
  // when it is hard-wired to zero.
  always_comb begin
    wr0_en = idle && (WE0_ == ENABLE_) && !(ZERO_REG && (WrAddr0 == '0));
    wr1_en = idle && (WE1_ == ENABLE_) && !(ZERO_REG && (WrAddr1 == '0));
    iss_en = idle && Issue && !(ZERO_REG && (IssueAddr == '0));
  end

  // Clear-engine next state: sweep the counter, restart on Clear, leave
  // CLEAR after the last entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      GPR_ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (Clear) begin
          cnt_d = '0;
        end else if (cnt_q == '1) begin
          state_d = GPR_ST_IDLE;
        end
      end
      GPR_ST_IDLE: begin
        if (Clear) begin
          state_d = GPR_ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = GPR_ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == GPR_ST_IDLE);
  end

  // Clear-engine state, counter and registered Ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= GPR_ST_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Storage: clear engine owns the array in CLEAR; otherwise port 1 then
  // port 0 so port 0 wins a same-address collision.
  always_ff @(posedge clk) begin
    if (clearing) begin
      mem_q[cnt_q] <= '0;
    end else begin
      if (wr1_en) mem_q[WrAddr1] <= WrData1;
      if (wr0_en) mem_q[WrAddr0] <= WrData0;
    end
  end

  // Combinational read ports with optional write forwarding.
  always_comb begin
    RdData = '0;
    ra     = '0;
    rd     = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = RdAddr[k*ADDR_W +: ADDR_W];
      rd = mem_q[ra];
`ifdef GPR_BYPASS_EN
      if (wr1_en && (WrAddr1 == ra)) rd = WrData1;
      if (wr0_en && (WrAddr0 == ra)) rd = WrData0;
`endif
      if (ZERO_REG && (ra == '0)) rd = '0;
      if (!idle)                  rd = '0;
      RdData[k*DATA_W +: DATA_W] = rd;
    end
  end

  // Busy lookups are suppressed while the clear engine is running.
  always_comb begin
    RdBusy = idle ? sb_busy : '0;
  end

  gpr_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .clr_en     (clearing),
    .clr_addr   (cnt_q),
    .set_en     (iss_en),
    .set_addr   (IssueAddr),
    .wclr0_en   (wr0_en),
    .wclr0_addr (WrAddr0),
    .wclr1_en   (wr1_en),
    .wclr1_addr (WrAddr1),
    .rd_addr    (RdAddr),
    .rd_busy    (sb_busy)
  );

endmodule

// File: tb/tb_gpr_bank.sv
// Self-checking bench for gpr_bank (default geometry: 32 x 32 bits, 2 read
// ports, ZERO_REG = 1). Directed scenarios followed by random traffic, all
// compared against a behavioural register-file model kept in the bench.
module tb_gpr_bank;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic           clk;
  logic           rst_i;
  logic           clr_i;
  logic           Ready;
  logic [AW-1:0]  rd_addr [NR];
  logic [NR*AW-1:0] RdAddr;
  logic [NR*DW-1:0] RdData;
  logic [NR-1:0]  RdBusy;
  logic           we0_n, we1_n, issue;
  logic [AW-1:0]  wa0, wa1, ia;
  logic [DW-1:0]  wd0, wd1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit             m_idle;
  int             m_cnt;
  logic [DW-1:0]  m_mem [DEPTH];
  bit             m_busy [DEPTH];

  assign RdAddr = {rd_addr[1], rd_addr[0]};

  gpr_bank #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1)) dut (
    .clk       (clk),
    .reset     (rst_i),
    .Clear     (clr_i),
    .Ready     (Ready),
    .RdAddr    (RdAddr),
    .RdData    (RdData),
    .RdBusy    (RdBusy),
    .WE0_      (we0_n),
    .WrAddr0   (wa0),
    .WrData0   (wd0),
    .WE1_      (we1_n),
    .WrAddr1   (wa1),
    .WrData1   (wd1),
    .Issue     (issue),
    .IssueAddr (ia)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (!m_idle || a == 0) return '0;
    v = m_mem[a];
`ifdef GPR_BYPASS_EN
    if (!we0_n && wa0 == a)      v = wd0;
    else if (!we1_n && wa1 == a) v = wd1;
`endif
    return v;
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    return m_idle ? m_busy[a] : 1'b0;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    if (rst_i) begin
      m_idle = 0;
      m_cnt  = 0;
    end else if (!m_idle) begin
      m_mem[m_cnt]  = '0;
      m_busy[m_cnt] = 0;
      if (clr_i)             m_cnt = 0;
      else if (m_cnt == DEPTH-1) m_idle = 1;
      else                   m_cnt = m_cnt + 1;
    end else begin
      if (!we1_n && wa1 != 0) begin m_mem[wa1] = wd1; m_busy[wa1] = 0; end
      if (!we0_n && wa0 != 0) begin m_mem[wa0] = wd0; m_busy[wa0] = 0; end
      if (issue && ia != 0) m_busy[ia] = 1;
      if (clr_i) begin
        m_idle = 0;
        m_cnt  = 0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("ready", {63'd0, Ready}, {63'd0, m_idle});
    for (int k = 0; k < NR; k++) begin
      chk("rd_data", {32'd0, RdData[k*DW +: DW]}, {32'd0, exp_rd(rd_addr[k])});
      chk("rd_busy", {63'd0, RdBusy[k]}, {63'd0, exp_busy(rd_addr[k])});
    end
  endtask

  // Check outputs, take one clock edge, update the model; ends at negedge.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_in();
    clr_i = 0; we0_n = 1; we1_n = 1; issue = 0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; ia = '0;
  endtask

  // Count cycles with Ready low while pushing activity that must be ignored.
  task automatic count_low(output int n);
    n = 0;
    while (Ready !== 1'b1 && n < 200) begin
      we0_n = 0; wa0 = 5'd3; wd0 = $urandom;
      we1_n = 0; wa1 = 5'd9; wd1 = $urandom;
      issue = 1; ia = 5'd3;
      rd_addr[0] = 5'd3; rd_addr[1] = 5'd9;
      n++;
      step();
    end
    idle_in();
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, DEPTH-1));
  endfunction

  int n;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
    m_idle = 0; m_cnt = 0;
    rst_i = 1; idle_in(); rd_addr[0] = '0; rd_addr[1] = 5'd1;
    @(negedge clk);
    chk("rst_ready", {63'd0, Ready}, 64'd0);
    chk("rst_busy", {62'd0, RdBusy}, 64'd0);
    chk("rst_data", RdData, 64'd0);

    // Reset release -> 32 cycles of clearing
    rst_i = 0;
    count_low(n);
    chk("ready_lat_reset", n, 32);
    for (int a = 0; a < DEPTH; a += 2) begin
      rd_addr[0] = AW'(a); rd_addr[1] = AW'(a + 1);
      #1 chk("post_clear_data", RdData, 64'd0);
      chk("post_clear_busy", {62'd0, RdBusy}, 64'd0);
      step();
    end

    // Port 0 write to r5, same-cycle and next-cycle read
    we0_n = 0; wa0 = 5'd5; wd0 = 32'hDEADBEEF; rd_addr[0] = 5'd5;
`ifdef GPR_BYPASS_EN
    #1 chk("r5_same_cycle", {32'd0, RdData[31:0]}, 64'hDEADBEEF);
`else
    #1 chk("r5_same_cycle", {32'd0, RdData[31:0]}, 64'd0);
`endif
    step();
    idle_in();
    #1 chk("r5_next_cycle", {32'd0, RdData[31:0]}, 64'hDEADBEEF);
    step();

    // Both ports to r7: port 0 wins
    we0_n = 0; wa0 = 5'd7; wd0 = 32'h11;
    we1_n = 0; wa1 = 5'd7; wd1 = 32'h22;
    step();
    idle_in(); rd_addr[0] = 5'd7;
    #1 chk("r7_priority", {32'd0, RdData[31:0]}, 64'h11);
    step();

    // Write to r0 is dropped
    we0_n = 0; wa0 = 5'd0; wd0 = 32'h55;
    step();
    idle_in(); rd_addr[0] = 5'd0;
    #1 chk("r0_zero", {32'd0, RdData[31:0]}, 64'd0);
    step();

    // Scoreboard: issue, write-clear, set-beats-clear
    issue = 1; ia = 5'd9; rd_addr[1] = 5'd9;
    #1 chk("r9_busy_same_cycle", {63'd0, RdBusy[1]}, 64'd0);
    step();
    idle_in();
    #1 chk("r9_busy_set", {63'd0, RdBusy[1]}, 64'd1);
    we1_n = 0; wa1 = 5'd9; wd1 = 32'h99;
    #1 chk("r9_busy_no_comb_clear", {63'd0, RdBusy[1]}, 64'd1);
    step();
    idle_in();
    #1 chk("r9_busy_cleared", {63'd0, RdBusy[1]}, 64'd0);
    issue = 1; ia = 5'd9; we0_n = 0; wa0 = 5'd9; wd0 = 32'hAA;
    step();
    idle_in();
    #1 chk("r9_set_wins", {63'd0, RdBusy[1]}, 64'd1);
    issue = 1; ia = 5'd0; rd_addr[0] = 5'd0;
    step();
    idle_in();
    #1 chk("r0_never_busy", {63'd0, RdBusy[0]}, 64'd0);
    step();

    // Clear pulse wipes r3
    we0_n = 0; wa0 = 5'd3; wd0 = 32'h1234;
    step();
    idle_in(); rd_addr[0] = 5'd3;
    #1 chk("r3_written", {32'd0, RdData[31:0]}, 64'h1234);
    clr_i = 1;
    step();
    clr_i = 0;
    count_low(n);
    chk("ready_lat_clear", n, 32);
    rd_addr[0] = 5'd3; rd_addr[1] = 5'd9;
    #1 chk("r3_after_clear", {32'd0, RdData[31:0]}, 64'd0);
    chk("busy_after_clear", {62'd0, RdBusy}, 64'd0);
    step();

    // Clear restarted at clear cycle 10
    clr_i = 1; step(); clr_i = 0;
    repeat (10) step();
    clr_i = 1; step(); clr_i = 0;
    count_low(n);
    chk("ready_lat_restart", n, 32);

    // Reset at clear cycle 20
    clr_i = 1; step(); clr_i = 0;
    repeat (20) step();
    rst_i = 1; step(); rst_i = 0;
    count_low(n);
    chk("ready_lat_reset_mid", n, 32);

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      rst_i = ($urandom_range(0, 399) == 0);
      clr_i = ($urandom_range(0, 149) == 0);
      we0_n = ($urandom_range(0, 2) == 0);
      we1_n = ($urandom_range(0, 2) == 0);
      issue = ($urandom_range(0, 2) == 0);
      wa0 = rnd_addr(); wa1 = rnd_addr(); ia = rnd_addr();
      wd0 = $urandom; wd1 = $urandom;
      rd_addr[0] = rnd_addr(); rd_addr[1] = rnd_addr();
      if ($urandom_range(0, 3) == 0) rd_addr[0] = wa0;
      if ($urandom_range(0, 3) == 0) rd_addr[1] = wa1;
      step();
    end
    rst_i = 0;
    idle_in();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
